// File: rtl/button_reader.sv
// Debounced push-button reader: two-flop synchroniser, debounce FSM, press/release/long-press
// events and an 8-bit press count. The release pulse port is release_pulse because release is a reserved word.
module button_reader #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_n,
   input  logic       clr,
   output logic       btn_state,
   output logic       press,
   output logic       release_pulse,
   output logic       long_press,
   output logic [7:0] count
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned LW = $clog2(LONG_CYCLES) + 1;

   localparam logic [DW-1:0] DB_ONE    = DW'(1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LONG_ONE  = LW'(1);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      DB_PRESS,
      HELD,
      DB_RELEASE
   } state_t;

   state_t          state, state_nx;
   logic            sync1, sync2;
   logic            s;
   logic [DW-1:0]   db_cnt, db_cnt_nx;
   logic [LW-1:0]   long_cnt, long_cnt_nx, long_inc;
   logic            btn_state_nx, press_nx, release_nx, long_nx;
   logic [7:0]      count_nx;

   // Both stages reset to the released level so reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   assign s        = ~sync2;
   assign long_inc = (long_cnt == LONG_SAT) ? long_cnt : long_cnt + LONG_ONE;

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         db_cnt        <= '0;
         long_cnt      <= '0;
         btn_state     <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         count         <= '0;
      end else begin
         state         <= state_nx;
         db_cnt        <= db_cnt_nx;
         long_cnt      <= long_cnt_nx;
         btn_state     <= btn_state_nx;
         press         <= press_nx;
         release_pulse <= release_nx;
         long_press    <= long_nx;
         count         <= count_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      db_cnt_nx   = db_cnt;
      long_cnt_nx = long_cnt;
      unique case (state)
         IDLE: begin
            if (s) begin
               state_nx  = DB_PRESS;
               db_cnt_nx = DB_ONE;
            end
         end
         DB_PRESS: begin
            if (!s) begin
               state_nx  = IDLE;
               db_cnt_nx = '0;
            end else if (db_cnt == DB_LAST) begin
               state_nx    = HELD;
               db_cnt_nx   = '0;
               long_cnt_nx = '0;
            end else begin
               db_cnt_nx = db_cnt + DB_ONE;
            end
         end
         HELD: begin
            long_cnt_nx = long_inc;
            if (!s) begin
               state_nx  = DB_RELEASE;
               db_cnt_nx = DB_ONE;
            end
         end
         DB_RELEASE: begin
            long_cnt_nx = long_inc;
            if (s) begin
               state_nx  = HELD;
               db_cnt_nx = '0;
            end else if (db_cnt == DB_LAST) begin
               state_nx  = IDLE;
               db_cnt_nx = '0;
            end else begin
               db_cnt_nx = db_cnt + DB_ONE;
            end
         end
         default: begin
            state_nx  = IDLE;
            db_cnt_nx = '0;
         end
      endcase
   end

   // Next values of the registered outputs; clr wins over the press increment.
   always_comb begin
      press_nx     = (state == DB_PRESS) && s && (db_cnt == DB_LAST);
      release_nx   = (state == DB_RELEASE) && !s && (db_cnt == DB_LAST);
      long_nx      = ((state == HELD) || (state == DB_RELEASE)) && (long_cnt == LONG_LAST);
      btn_state_nx = (state_nx == HELD) || (state_nx == DB_RELEASE);
      if (clr)
         count_nx = '0;
      else if (press_nx)
         count_nx = count + 8'd1;
      else
         count_nx = count;
   end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_n;
   logic       clr;
   logic       btn_state;
   logic       press;
   logic       release_pulse;
   logic       long_press;
   logic [7:0] count;

   int total = 0;
   int bad   = 0;
   int n_press = 0, n_rel = 0, n_long = 0;

   button_reader #(
      .DEBOUNCE_CYCLES(4),
      .LONG_CYCLES(20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_n(btn_n),
      .clr(clr),
      .btn_state(btn_state),
      .press(press),
      .release_pulse(release_pulse),
      .long_press(long_press),
      .count(count)
   );

   always #5 clk = ~clk;

   // Pulse tallies, sampled at the rising edge (pre-update values).
   always @(posedge clk) begin
      if (press)         n_press++;
      if (release_pulse) n_rel++;
      if (long_press)    n_long++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press_release();
      btn_n = 1'b0;
      repeat (8) tick();
      btn_n = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      rst   = 1'b1;
      btn_n = 1'b1;
      clr   = 1'b0;
      repeat (2) tick();
      chk("rst_state", btn_state, 0);
      chk("rst_press", press, 0);
      chk("rst_release", release_pulse, 0);
      chk("rst_long", long_press, 0);
      chk("rst_count", count, 0);
      rst = 1'b0;
      repeat (3) tick();

      // Clean press held 10 cycles, then release
      btn_n = 1'b0;
      repeat (5) tick();
      chk("t1_press_early", press, 0);
      chk("t1_state_early", btn_state, 0);
      tick();
      chk("t1_press", press, 1);
      chk("t1_state", btn_state, 1);
      chk("t1_count", count, 1);
      tick();
      chk("t1_press_once", press, 0);
      repeat (3) tick();
      btn_n = 1'b1;
      repeat (5) tick();
      chk("t1_rel_early", release_pulse, 0);
      chk("t1_state_held", btn_state, 1);
      tick();
      chk("t1_release", release_pulse, 1);
      chk("t1_state_rel", btn_state, 0);
      tick();
      chk("t1_rel_once", release_pulse, 0);
      repeat (3) tick();
      chk("t1_n_press", n_press, 1);
      chk("t1_n_rel", n_rel, 1);
      chk("t1_n_long", n_long, 0);

      // Bounce: low 2, high 1, then steady low
      btn_n = 1'b0;
      repeat (2) tick();
      btn_n = 1'b1;
      tick();
      btn_n = 1'b0;
      repeat (5) tick();
      chk("t2_no_bounce_evt", n_press, 1);
      chk("t2_state_early", btn_state, 0);
      chk("t2_count_early", count, 1);
      tick();
      chk("t2_press", press, 1);
      chk("t2_count", count, 2);

      // Continue holding: long_press 20 edges after the press edge
      repeat (19) tick();
      chk("t3_long_early", long_press, 0);
      tick();
      chk("t3_long", long_press, 1);
      tick();
      chk("t3_long_once", long_press, 0);
      repeat (20) tick();
      chk("t3_n_long", n_long, 1);
      chk("t3_n_press", n_press, 2);
      btn_n = 1'b1;
      repeat (5) tick();
      chk("t3_rel_early", release_pulse, 0);
      tick();
      chk("t3_release", release_pulse, 1);
      chk("t3_state_rel", btn_state, 0);
      repeat (3) tick();
      chk("t3_n_rel", n_rel, 2);
      chk("t3_n_long_after", n_long, 1);

      // clr with no press pending
      repeat (3) press_release();
      chk("t4_count5", count, 5);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t4_clr", count, 0);

      // Wrap-around
      repeat (255) press_release();
      chk("t4_count255", count, 255);
      press_release();
      chk("t4_wrap", count, 0);
      press_release();
      chk("t4_after_wrap", count, 1);
      chk("t4_n_press", n_press, 2 + 3 + 257);

      // clr on the same edge a press is accepted
      btn_n = 1'b0;
      repeat (5) tick();
      chk("t5_press_early", press, 0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t5_press", press, 1);
      chk("t5_count", count, 0);
      tick();
      chk("t5_count_hold", count, 0);
      repeat (2) tick();
      btn_n = 1'b1;
      repeat (8) tick();

      // Async reset while held with count=3
      repeat (2) press_release();
      btn_n = 1'b0;
      repeat (8) tick();
      chk("t6_count3", count, 3);
      chk("t6_held", btn_state, 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_state", btn_state, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_press", press, 0);
      chk("t6_rst_long", long_press, 0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("t6_post_early", press, 0);
      chk("t6_post_rel", release_pulse, 0);
      chk("t6_post_state", btn_state, 0);
      tick();
      chk("t6_post_press", press, 1);
      chk("t6_post_count", count, 1);
      repeat (3) tick();
      chk("t6_n_rel", n_rel, 2 + 3 + 257 + 1 + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
